nx_ram_2rw_sched: RTL and testbench

Scheduler placed in front of a dual-port (2RW) RAM instance. It shares the RAM's two ports among NUM_REQ requesters using round-robin arbitration and blocks same-address hazards. It tracks fixed read latency and returns read data tagged with requester ID. After reset, or on request, it runs an init sequencer that fills the whole array with INIT_VAL using both ports.

---
 rtl/nx_ram_2rw_sched_if.sv | 39 +++
 rtl/nx_ram_2rw_sched.sv | 194 +++++++++++++++++++
 tb/tb_nx_ram_2rw_sched.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/nx_ram_2rw_sched_if.sv
// Request/response bundle between requesters and the 2RW RAM scheduler.
// Latency: none, plain wires. Backpressure: req_ready per requester; responses cannot be stalled.
// Ports: req_valid/req_ready/req_we/req_addr/req_wdata (packed per requester),
//        rsp_{a,b}_valid/id/data (one response lane per RAM port).
interface nx_ram_2rw_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 64,
  parameter int AW      = 8,
  parameter int IDW     = 2
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0]       req_we;
  logic [NUM_REQ*AW-1:0]    req_addr;
  logic [NUM_REQ*WIDTH-1:0] req_wdata;

  logic                     rsp_a_valid;
  logic [IDW-1:0]           rsp_a_id;
  logic [WIDTH-1:0]         rsp_a_data;
  logic                     rsp_b_valid;
  logic [IDW-1:0]           rsp_b_id;
  logic [WIDTH-1:0]         rsp_b_data;

  // Requester side
  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready,
    input  rsp_a_valid, rsp_a_id, rsp_a_data,
    input  rsp_b_valid, rsp_b_id, rsp_b_data
  );

  // Scheduler side
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready,
    output rsp_a_valid, rsp_a_id, rsp_a_data,
    output rsp_b_valid, rsp_b_id, rsp_b_data
  );
endinterface

// File: rtl/nx_ram_2rw_sched.sv
// Shares a 2RW RAM among NUM_REQ requesters (round-robin, same-address hazard block) and fills it with INIT_VAL.
// Latency: accepted request hits the RAM in the same cycle; read data returns RAM_LAT cycles later tagged with requester id.
// Backpressure: req_ready only for granted requesters; none during fill or on an init_req cycle; responses are never stalled.
// Ports: clk, rst_n (async, active low); init_req/init_done; bus (slave modport of nx_ram_2rw_sched_if);
//        RAM side csa/wea/adda/dina/bwea/douta and csb/web/addb/dinb/bweb/doutb.
module nx_ram_2rw_sched #(
  parameter int               NUM_REQ  = 4,
  parameter int               WIDTH    = 64,
  parameter int               DEPTH    = 256,
  parameter int               RAM_LAT  = 2,
  parameter logic [WIDTH-1:0] INIT_VAL = '0,
  localparam int              AW       = $clog2(DEPTH),
  localparam int              IDW      = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 init_req,
  output logic                 init_done,
  nx_ram_2rw_sched_if.slave    bus,
  output logic                 csa,
  output logic                 wea,
  output logic [AW-1:0]        adda,
  output logic [WIDTH-1:0]     dina,
  output logic [WIDTH-1:0]     bwea,
  input  logic [WIDTH-1:0]     douta,
  output logic                 csb,
  output logic                 web,
  output logic [AW-1:0]        addb,
  output logic [WIDTH-1:0]     dinb,
  output logic [WIDTH-1:0]     bweb,
  input  logic [WIDTH-1:0]     doutb
);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e             state_q, state_d;
  // One spare bit so cnt+1 / cnt+2 can reach DEPTH without wrapping.
  logic [AW:0]        cnt_q, cnt_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [RAM_LAT-1:0] pa_vld_q, pa_vld_d, pb_vld_q, pb_vld_d;
  logic [IDW-1:0]     pa_id_q [RAM_LAT];
  logic [IDW-1:0]     pa_id_d [RAM_LAT];
  logic [IDW-1:0]     pb_id_q [RAM_LAT];
  logic [IDW-1:0]     pb_id_d [RAM_LAT];

  logic               a_found, b_found;
  logic [IDW-1:0]     a_idx, b_idx;
  logic [IDW:0]       scan;
  logic               a_we, b_we;
  logic [AW-1:0]      a_addr, b_addr;
  logic               hazard, grant_a, grant_b;
  logic [AW:0]        cnt_b, cnt_nxt;

  function automatic logic [IDW-1:0] nxt_idx(input logic [IDW-1:0] i);
    return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
  endfunction

  // Round-robin scan from ptr_q: first valid goes to port A, second to port B.
  always_comb begin
    a_found = 1'b0;
    b_found = 1'b0;
    a_idx   = '0;
    b_idx   = '0;
    scan    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = {1'b0, ptr_q} + (IDW+1)'(k);
      if (scan >= (IDW+1)'(NUM_REQ)) scan = scan - (IDW+1)'(NUM_REQ);
      if (bus.req_valid[scan[IDW-1:0]]) begin
        if (!a_found) begin
          a_found = 1'b1;
          a_idx   = scan[IDW-1:0];
        end else if (!b_found) begin
          b_found = 1'b1;
          b_idx   = scan[IDW-1:0];
        end
      end
    end
    a_we   = bus.req_we[a_idx];
    b_we   = bus.req_we[b_idx];
    a_addr = bus.req_addr[int'(a_idx)*AW +: AW];
    b_addr = bus.req_addr[int'(b_idx)*AW +: AW];
    // Same-address access with any write would race inside the RAM; B waits.
    hazard  = a_found && b_found && (a_addr == b_addr) && (a_we || b_we);
    grant_a = (state_q == ST_RUN) && !init_req && a_found;
    grant_b = grant_a && b_found && !hazard;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    pa_vld_d = pa_vld_q;
    pb_vld_d = pb_vld_q;
    pa_id_d  = pa_id_q;
    pb_id_d  = pb_id_q;
    csa      = 1'b0;
    wea      = 1'b0;
    adda     = '0;
    dina     = '0;
    csb      = 1'b0;
    web      = 1'b0;
    addb     = '0;
    dinb     = '0;
    bus.req_ready = '0;
    cnt_b    = cnt_q + (AW+1)'(1);
    cnt_nxt  = cnt_q + (AW+1)'(2);

    case (state_q)
      ST_INIT: begin
        // rst_n gate keeps the RAM quiet while reset is held.
        csa  = rst_n;
        wea  = rst_n;
        adda = cnt_q[AW-1:0];
        dina = INIT_VAL;
        // Odd DEPTH: port B has no word left on the last fill cycle.
        csb  = rst_n && (cnt_b < (AW+1)'(DEPTH));
        web  = csb;
        addb = cnt_b[AW-1:0];
        dinb = INIT_VAL;
        if (cnt_nxt >= (AW+1)'(DEPTH)) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_nxt;
        end
      end
      default: begin
        if (init_req) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end
        if (grant_a) begin
          csa  = 1'b1;
          wea  = a_we;
          adda = a_addr;
          dina = bus.req_wdata[int'(a_idx)*WIDTH +: WIDTH];
          bus.req_ready = bus.req_ready | (NUM_REQ'(1) << a_idx);
          ptr_d = nxt_idx(a_idx);
        end
        if (grant_b) begin
          csb  = 1'b1;
          web  = b_we;
          addb = b_addr;
          dinb = bus.req_wdata[int'(b_idx)*WIDTH +: WIDTH];
          bus.req_ready = bus.req_ready | (NUM_REQ'(1) << b_idx);
          ptr_d = nxt_idx(b_idx);
        end
      end
    endcase

    // Read-latency tracking keeps shifting in every state so in-flight reads drain through a refill.
    for (int i = RAM_LAT - 1; i > 0; i--) begin
      pa_vld_d[i] = pa_vld_q[i-1];
      pa_id_d[i]  = pa_id_q[i-1];
      pb_vld_d[i] = pb_vld_q[i-1];
      pb_id_d[i]  = pb_id_q[i-1];
    end
    pa_vld_d[0] = grant_a && !a_we;
    pa_id_d[0]  = a_idx;
    pb_vld_d[0] = grant_b && !b_we;
    pb_id_d[0]  = b_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_INIT;
      cnt_q    <= '0;
      ptr_q    <= '0;
      pa_vld_q <= '0;
      pb_vld_q <= '0;
      pa_id_q  <= '{default: '0};
      pb_id_q  <= '{default: '0};
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      pa_vld_q <= pa_vld_d;
      pb_vld_q <= pb_vld_d;
      pa_id_q  <= pa_id_d;
      pb_id_q  <= pb_id_d;
    end
  end

  assign init_done       = (state_q == ST_RUN);
  assign bwea            = '1;
  assign bweb            = '1;
  assign bus.rsp_a_valid = pa_vld_q[RAM_LAT-1];
  assign bus.rsp_a_id    = pa_id_q[RAM_LAT-1];
  assign bus.rsp_a_data  = douta;
  assign bus.rsp_b_valid = pb_vld_q[RAM_LAT-1];
  assign bus.rsp_b_id    = pb_id_q[RAM_LAT-1];
  assign bus.rsp_b_data  = doutb;

endmodule

// File: tb/tb_nx_ram_2rw_sched.sv
// Directed bench for nx_ram_2rw_sched: 4 requesters, 8-bit words, 8-deep RAM, RAM_LAT=2.
// Inputs change 1 time unit after each rising edge and outputs are checked 1 unit later.
// Ports: none (top-level bench).
module tb_nx_ram_2rw_sched;
  localparam int NR  = 4;
  localparam int W   = 8;
  localparam int D   = 8;
  localparam int LAT = 2;
  localparam int AW  = 3;
  localparam int IDW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          init_req = 1'b0;
  logic          init_done;
  logic          csa, wea, csb, web;
  logic [AW-1:0] adda, addb;
  logic [W-1:0]  dina, dinb, bwea, bweb, douta, doutb;

  int n_cmp = 0;
  int n_err = 0;

  nx_ram_2rw_sched_if #(.NUM_REQ(NR), .WIDTH(W), .AW(AW), .IDW(IDW)) bus ();

  nx_ram_2rw_sched #(
    .NUM_REQ(NR), .WIDTH(W), .DEPTH(D), .RAM_LAT(LAT), .INIT_VAL(8'h00)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .init_req(init_req), .init_done(init_done),
    .bus(bus.slave),
    .csa(csa), .wea(wea), .adda(adda), .dina(dina), .bwea(bwea), .douta(douta),
    .csb(csb), .web(web), .addb(addb), .dinb(dinb), .bweb(bweb), .doutb(doutb)
  );

  always #5 clk = ~clk;

  // RAM model: 1-cycle array read plus output flop = 2 cycles; preloaded with junk.
  logic [W-1:0] mem [D] = '{default: 8'hEE};
  logic [W-1:0] a1 = '0, a2 = '0, b1 = '0, b2 = '0;
  always @(posedge clk) begin
    if (csa && wea)  mem[adda] <= dina;
    if (csb && web)  mem[addb] <= dinb;
    if (csa && !wea) a1 <= mem[adda];
    if (csb && !web) b1 <= mem[addb];
    a2 <= a1;
    b2 <= b1;
  end
  assign douta = a2;
  assign doutb = b2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int i, input bit v, input bit we, input int a, input int d);
    bus.req_valid[i]          = v;
    bus.req_we[i]             = we;
    bus.req_addr[i*AW +: AW]  = a[AW-1:0];
    bus.req_wdata[i*W +: W]   = d[W-1:0];
  endtask

  task automatic idle_all();
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
  endtask

  task automatic chk_rsp_a(input string tag, input bit v, input int id, input int d);
    chk({tag, "_a_vld"}, bus.rsp_a_valid, v);
    if (v) begin
      chk({tag, "_a_id"}, bus.rsp_a_id, id);
      chk({tag, "_a_dat"}, bus.rsp_a_data, d);
    end
  endtask

  task automatic chk_rsp_b(input string tag, input bit v, input int id, input int d);
    chk({tag, "_b_vld"}, bus.rsp_b_valid, v);
    if (v) begin
      chk({tag, "_b_id"}, bus.rsp_b_id, id);
      chk({tag, "_b_dat"}, bus.rsp_b_data, d);
    end
  endtask

  initial begin
    idle_all();
    cyc();
    cyc();
    // Reset held
    chk("rst_init_done", init_done, 0);
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_csa", csa, 0);
    chk("rst_csb", csb, 0);
    chk("rst_bwea", bwea, 8'hFF);
    chk("rst_bweb", bweb, 8'hFF);
    chk("rst_rsp_a", bus.rsp_a_valid, 0);

    // Fill: 4 cycles writing (0,1),(2,3),(4,5),(6,7)
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("fill_csa", csa, 1);
      chk("fill_wea", wea, 1);
      chk("fill_adda", adda, 2*k);
      chk("fill_csb", csb, 1);
      chk("fill_web", web, 1);
      chk("fill_addb", addb, 2*k+1);
      chk("fill_dina", dina, 0);
      chk("fill_done", init_done, 0);
      cyc();
    end
    chk("run_done", init_done, 1);

    // Read all 8 words: req0 even, req1 odd; ptr ends at 2
    for (int k = 0; k < 6; k++) begin
      if (k < 4) begin
        drv(0, 1, 0, 2*k, 0);
        drv(1, 1, 0, 2*k+1, 0);
      end else begin
        idle_all();
      end
      #1;
      if (k < 4) chk("rd_ready", bus.req_ready, 4'b0011);
      chk_rsp_a("rd0", k >= 2, 0, 0);
      chk_rsp_b("rd0", k >= 2, 1, 0);
      cyc();
    end

    // Write 0xAA to addr 3 (req0), then read it back (req1)
    drv(0, 1, 1, 3, 8'hAA);
    #1;
    chk("wr_ready", bus.req_ready, 4'b0001);
    chk("wr_csa", csa, 1);
    chk("wr_wea", wea, 1);
    chk("wr_adda", adda, 3);
    chk("wr_dina", dina, 8'hAA);
    chk("wr_csb", csb, 0);
    cyc();
    idle_all();
    drv(1, 1, 0, 3, 0);
    #1;
    chk("rb_ready", bus.req_ready, 4'b0010);
    chk("rb_wea", wea, 0);
    cyc();
    idle_all();
    #1;
    chk_rsp_a("rb_early", 0, 0, 0);
    cyc();
    chk_rsp_a("rb", 1, 1, 8'hAA);

    // All four reading continuously from ptr=2: (2,3),(0,1),(2,3),(0,1)
    for (int k = 0; k < 6; k++) begin
      if (k < 4) begin
        for (int i = 0; i < NR; i++) drv(i, 1, 0, i, 0);
      end else begin
        idle_all();
      end
      #1;
      if (k < 4) chk("rr_ready", bus.req_ready, (k % 2 == 0) ? 4'b1100 : 4'b0011);
      if (k >= 2) begin
        chk_rsp_a("rr", 1, (k % 2 == 0) ? 2 : 0, 0);
        chk_rsp_b("rr", 1, (k % 2 == 0) ? 3 : 1, (k % 2 == 0) ? 8'hAA : 0);
      end
      cyc();
    end

    // Hazard: req0 writes 5, req1 reads 5 -> only req0 accepted
    drv(0, 1, 1, 5, 8'h55);
    drv(1, 1, 0, 5, 0);
    #1;
    chk("hz_ready", bus.req_ready, 4'b0001);
    chk("hz_csb", csb, 0);
    cyc();
    drv(0, 0, 0, 0, 0);
    #1;
    chk("hz_retry_ready", bus.req_ready, 4'b0010);
    chk("hz_retry_adda", adda, 5);
    cyc();
    idle_all();
    #1;
    cyc();
    chk_rsp_a("hz", 1, 1, 8'h55);

    // Two reads of the same address in one cycle are both granted
    drv(0, 1, 0, 5, 0);
    drv(1, 1, 0, 5, 0);
    #1;
    chk("same_ready", bus.req_ready, 4'b0011);
    chk("same_addb", addb, 5);
    cyc();
    idle_all();
    #1;
    cyc();
    chk_rsp_a("same", 1, 0, 8'h55);
    chk_rsp_b("same", 1, 1, 8'h55);

    // Read addr 3, then init_req: response still returns pre-fill data
    drv(0, 1, 0, 3, 0);
    #1;
    chk("ir_rd_ready", bus.req_ready, 4'b0001);
    cyc();
    idle_all();
    drv(2, 1, 0, 0, 0);
    init_req = 1'b1;
    #1;
    chk("ir_ready", bus.req_ready, 0);
    chk("ir_csa", csa, 0);
    chk("ir_done", init_done, 1);
    cyc();
    init_req = 1'b0;
    #1;
    chk("refill_done", init_done, 0);
    chk("refill_ready", bus.req_ready, 0);
    chk("refill_adda0", adda, 0);
    chk("refill_wea", wea, 1);
    chk_rsp_a("ir", 1, 0, 8'hAA);
    cyc();
    init_req = 1'b1;   // ignored while filling
    #1;
    chk("refill_adda1", adda, 2);
    cyc();
    init_req = 1'b0;
    #1;
    chk("refill_adda2", adda, 4);
    cyc();
    chk("refill_adda3", adda, 6);
    chk("refill_done3", init_done, 0);
    cyc();
    chk("refill_run", init_done, 1);
    chk("post_ready2", bus.req_ready, 4'b0100);
    cyc();
    drv(2, 0, 0, 0, 0);
    drv(0, 1, 0, 3, 0);
    #1;
    chk("post_ready0", bus.req_ready, 4'b0001);
    cyc();
    idle_all();
    #1;
    chk_rsp_a("post2", 1, 2, 0);
    cyc();
    chk_rsp_a("post0", 1, 0, 0);

    // Reset while a read is in flight drops it and restarts the fill
    drv(1, 1, 0, 3, 0);
    #1;
    chk("mr_ready", bus.req_ready, 4'b0010);
    cyc();
    idle_all();
    rst_n = 1'b0;
    #1;
    chk("mr_rsp", bus.rsp_a_valid, 0);
    chk("mr_done", init_done, 0);
    chk("mr_csa", csa, 0);
    cyc();
    rst_n = 1'b1;
    #1;
    chk("mr_fill_csa", csa, 1);
    chk("mr_fill_adda", adda, 0);
    chk("mr_rsp2", bus.rsp_a_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
